pwm_ramp_sequencer: RTL and testbench

// Sequences the duty/resolution configuration of the 8-bit PWM generator.

---
 rtl/pwm_ramp_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_pwm_ramp_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_sequencer.sv
// pwm_ramp_sequencer
// Walks the PWM duty toward a commanded target, one step per (dwell+1)
// PWM periods, and owns the PWM resolution setting. The resolution only
// changes at command accept, because the PWM restarts its counter whenever
// bits changes; a change of resolution also restarts the ramp from zero.
`timescale 1ns/1ps

module pwm_ramp_sequencer #(
    parameter int DW      = 8,
    parameter int BW      = 3,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [DW-1:0]      cfg_target,
    input  logic [DW-1:0]      cfg_step,
    input  logic [BW-1:0]      cfg_bits,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               abort,
    input  logic               period_end,
    output logic [DW-1:0]      duty_out,
    output logic [BW-1:0]      bits_out,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_STEP  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [DW-1:0]        tgt_r;
    logic [DW-1:0]        step_r;
    logic [DWELL_W-1:0]   dwell_r;
    logic [DWELL_W-1:0]   dwell_cnt_r;

    logic                 cfg_ready_s;
    logic                 accept_s;
    logic [DW:0]          full_scale_s;
    logic [DW-1:0]        acc_tgt_s;
    logic [DW-1:0]        acc_duty_s;
    logic [DW:0]          sum_s;
    logic [DW-1:0]        room_s;
    logic [DW-1:0]        step_duty_s;

    // Handshake: ready only in IDLE, never during reset, and abort vetoes it.
    always_comb begin
        cfg_ready_s = (state_r == ST_IDLE) && !rst && !abort;
        accept_s    = cfg_valid && cfg_ready_s;
    end

    // Accept-time values: target clamped to 2**bits (compared one bit wider),
    // and the starting duty (zero when resolution changes).
    always_comb begin
        full_scale_s = {{DW{1'b0}}, 1'b1} << cfg_bits;
        if ({1'b0, cfg_target} < full_scale_s) begin
            acc_tgt_s = cfg_target;
        end else begin
            acc_tgt_s = full_scale_s[DW-1:0];
        end
        if (cfg_bits != bits_out) begin
            acc_duty_s = {DW{1'b0}};
        end else begin
            acc_duty_s = duty_out;
        end
    end

    // Next duty for a STEP cycle: saturating move toward target, never past it.
    always_comb begin
        sum_s  = {1'b0, duty_out} + {1'b0, step_r};
        room_s = duty_out - tgt_r;
        if (step_r == {DW{1'b0}}) begin
            step_duty_s = tgt_r;
        end else if (duty_out < tgt_r) begin
            if (sum_s >= {1'b0, tgt_r}) begin
                step_duty_s = tgt_r;
            end else begin
                step_duty_s = sum_s[DW-1:0];
            end
        end else begin
            if (step_r >= room_s) begin
                step_duty_s = tgt_r;
            end else begin
                step_duty_s = duty_out - step_r;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; abort always wins over period_end and accept.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (acc_duty_s == acc_tgt_s) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_DWELL;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DWELL: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (period_end && (dwell_cnt_r == dwell_r)) begin
                    state_s = ST_STEP;
                end else begin
                    state_s = ST_DWELL;
                end
            end
            ST_STEP: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (step_duty_s == tgt_r) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DWELL;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Datapath registers: command latch, dwell counter, duty and resolution.
    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_r       <= {DW{1'b0}};
            step_r      <= {DW{1'b0}};
            dwell_r     <= {DWELL_W{1'b0}};
            dwell_cnt_r <= {DWELL_W{1'b0}};
            duty_out    <= {DW{1'b0}};
            bits_out    <= {BW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        tgt_r       <= acc_tgt_s;
                        step_r      <= cfg_step;
                        dwell_r     <= cfg_dwell;
                        dwell_cnt_r <= {DWELL_W{1'b0}};
                        duty_out    <= acc_duty_s;
                        bits_out    <= cfg_bits;
                    end
                end
                ST_DWELL: begin
                    if (!abort && period_end) begin
                        if (dwell_cnt_r == dwell_r) begin
                            dwell_cnt_r <= {DWELL_W{1'b0}};
                        end else begin
                            dwell_cnt_r <= dwell_cnt_r + {{(DWELL_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_STEP: begin
                    if (!abort) begin
                        duty_out <= step_duty_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status outputs decoded from the state register.
    always_comb begin
        cfg_ready = cfg_ready_s;
        busy      = (state_r == ST_DWELL) || (state_r == ST_STEP);
        done      = (state_r == ST_DONE);
    end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Testbench for pwm_ramp_sequencer: table of ramp commands with expected
// duty sequences fed through a scoreboard queue, plus hand-written
// sequences for abort, update latency and mid-ramp reset.
`timescale 1ns/1ps

module tb_pwm_ramp_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_target;
    logic [7:0] cfg_step;
    logic [2:0] cfg_bits;
    logic [3:0] cfg_dwell;
    logic       abort;
    logic       period_end;
    logic [7:0] duty_out;
    logic [2:0] bits_out;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    pwm_ramp_sequencer #(.DW(8), .BW(3), .DWELL_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_target (cfg_target),
        .cfg_step   (cfg_step),
        .cfg_bits   (cfg_bits),
        .cfg_dwell  (cfg_dwell),
        .abort      (abort),
        .period_end (period_end),
        .duty_out   (duty_out),
        .bits_out   (bits_out),
        .busy       (busy),
        .done       (done)
    );

    typedef struct packed {
        logic [2:0]      bits;
        logic [7:0]      tgt;
        logic [7:0]      step;
        logic [3:0]      dwell;
        logic [3:0]      n;         // number of expected duty changes
        logic [7:0]      pe;        // period_end pulses needed to finish
        logic [3:0][7:0] duty_seq;  // expected duty values, in order
    } vec_t;

    vec_t       vecs [10];
    logic [7:0] exp_q [$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         done_cnt = 0;
    logic [7:0] prev_duty = 8'd0;

    task automatic check(input string name, input int act, input int want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] b, input logic [7:0] t, input logic [7:0] s,
                                input logic [3:0] d, input logic [3:0] n, input logic [7:0] pe,
                                input logic [7:0] e0, input logic [7:0] e1,
                                input logic [7:0] e2, input logic [7:0] e3);
        vec_t v;
        v.bits     = b;
        v.tgt      = t;
        v.step     = s;
        v.dwell    = d;
        v.n        = n;
        v.pe       = pe;
        v.duty_seq = {e3, e2, e1, e0};
        return v;
    endfunction

    // Scoreboard: every duty_out change must match the next queued value;
    // also counts done pulses.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
        end
        if (rst === 1'b0 && duty_out !== prev_duty) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL duty_unexpected: got %0d, expected no change from %0d", duty_out, prev_duty);
            end else begin
                check("duty_seq", int'(duty_out), int'(exp_q.pop_front()));
            end
        end
        prev_duty = duty_out;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] b, input logic [7:0] t, input logic [7:0] s,
                        input logic [3:0] d);
        int w = 0;
        while (!cfg_ready && w < 50) begin
            tick;
            w++;
        end
        check("cfg_ready_wait", int'(cfg_ready), 1);
        cfg_bits   = b;
        cfg_target = t;
        cfg_step   = s;
        cfg_dwell  = d;
        cfg_valid  = 1'b1;
        tick;
        cfg_valid  = 1'b0;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   pulses = 0;
        bit   got    = 1'b0;
        v = vecs[i];
        done_cnt = 0;
        for (int k = 0; k < int'(v.n); k++) begin
            exp_q.push_back(v.duty_seq[k]);
        end
        send(v.bits, v.tgt, v.step, v.dwell);
        check($sformatf("busy_after_accept[%0d]", i), int'(busy), (v.pe != 8'd0) ? 1 : 0);
        for (int it = 0; it < 400; it++) begin
            tick;
            period_end = 1'b0;
            if (done_cnt > 0) begin
                got = 1'b1;
                break;
            end
            if (it % 4 == 0) begin
                period_end = 1'b1;
                pulses++;
            end
        end
        period_end = 1'b0;
        check($sformatf("done_seen[%0d]", i), int'(got), 1);
        tick;
        tick;
        check($sformatf("done_once[%0d]", i), done_cnt, 1);
        check($sformatf("pulses_used[%0d]", i), pulses, int'(v.pe));
        check($sformatf("queue_drained[%0d]", i), exp_q.size(), 0);
        check($sformatf("bits_out[%0d]", i), int'(bits_out), int'(v.bits));
        if (v.n != 4'd0) begin
            check($sformatf("final_duty[%0d]", i), int'(duty_out), int'(v.duty_seq[v.n - 4'd1]));
        end else begin
            check($sformatf("final_duty[%0d]", i), int'(duty_out), int'(v.tgt));
        end
    endtask

    initial begin
        //             bits  tgt     step    dwell n     pe     duty sequence
        vecs[0] = mk(3'd7, 8'd100, 8'd30,  4'd0, 4'd4, 8'd4, 8'd30, 8'd60, 8'd90,  8'd100);
        vecs[1] = mk(3'd7, 8'd10,  8'd40,  4'd2, 4'd3, 8'd9, 8'd60, 8'd20, 8'd10,  8'd0);
        vecs[2] = mk(3'd3, 8'd200, 8'd0,   4'd0, 4'd2, 8'd1, 8'd0,  8'd8,  8'd0,   8'd0);
        vecs[3] = mk(3'd5, 8'd20,  8'd7,   4'd1, 4'd4, 8'd6, 8'd0,  8'd7,  8'd14,  8'd20);
        vecs[4] = mk(3'd5, 8'd20,  8'd3,   4'd0, 4'd0, 8'd0, 8'd0,  8'd0,  8'd0,   8'd0);
        vecs[5] = mk(3'd0, 8'd50,  8'd0,   4'd0, 4'd2, 8'd1, 8'd0,  8'd1,  8'd0,   8'd0);
        vecs[6] = mk(3'd7, 8'd255, 8'd200, 4'd0, 4'd2, 8'd1, 8'd0,  8'd128, 8'd0,  8'd0);
        vecs[7] = mk(3'd7, 8'd5,   8'd200, 4'd0, 4'd1, 8'd1, 8'd5,  8'd0,  8'd0,   8'd0);
        vecs[8] = mk(3'd7, 8'd60,  8'd0,   4'd0, 4'd1, 8'd1, 8'd60, 8'd0,  8'd0,   8'd0);
        vecs[9] = mk(3'd7, 8'd3,   8'd1,   4'd0, 4'd3, 8'd3, 8'd1,  8'd2,  8'd3,   8'd0);

        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_target = 8'd0;
        cfg_step   = 8'd0;
        cfg_bits   = 3'd0;
        cfg_dwell  = 4'd0;
        abort      = 1'b0;
        period_end = 1'b0;
        tick;
        tick;
        check("reset_duty", int'(duty_out), 0);
        check("reset_bits", int'(bits_out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_ready", int'(cfg_ready), 0);
        rst = 1'b0;
        #1;
        check("ready_after_reset", int'(cfg_ready), 1);

        for (int i = 0; i < 9; i++) begin
            run_vec(i);
        end

        // Abort together with period_end mid-ramp at duty 60.
        done_cnt = 0;
        send(3'd7, 8'd120, 8'd30, 4'd0);
        check("abort_busy_before", int'(busy), 1);
        abort      = 1'b1;
        period_end = 1'b1;
        tick;
        abort      = 1'b0;
        period_end = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_duty_hold", int'(duty_out), 60);
        check("abort_ready", int'(cfg_ready), 1);
        period_end = 1'b1;
        tick;
        period_end = 1'b0;
        tick;
        tick;
        check("abort_no_done", done_cnt, 0);
        check("abort_pe_ignored", int'(duty_out), 60);

        // Abort in IDLE vetoes a simultaneous command.
        cfg_bits   = 3'd2;
        cfg_target = 8'd0;
        cfg_step   = 8'd0;
        cfg_valid  = 1'b1;
        abort      = 1'b1;
        #1;
        check("abort_idle_ready", int'(cfg_ready), 0);
        tick;
        cfg_valid = 1'b0;
        abort     = 1'b0;
        #1;
        check("abort_idle_bits", int'(bits_out), 7);
        check("abort_idle_busy", int'(busy), 0);
        check("abort_idle_duty", int'(duty_out), 60);

        // Duty update lands two clocks after the qualifying period_end.
        done_cnt = 0;
        exp_q.push_back(8'd70);
        send(3'd7, 8'd70, 8'd10, 4'd0);
        period_end = 1'b1;
        tick;
        period_end = 1'b0;
        check("latency_1clk", int'(duty_out), 60);
        tick;
        check("latency_2clk", int'(duty_out), 70);
        check("latency_done", int'(done), 1);
        tick;
        tick;
        check("latency_done_once", done_cnt, 1);

        // Reset in the middle of a ramp.
        done_cnt = 0;
        exp_q.push_back(8'd80);
        exp_q.push_back(8'd90);
        send(3'd7, 8'd200, 8'd10, 4'd0);
        for (int p = 0; p < 2; p++) begin
            period_end = 1'b1;
            tick;
            period_end = 1'b0;
            tick;
            tick;
            tick;
        end
        check("midramp_duty", int'(duty_out), 90);
        check("midramp_busy", int'(busy), 1);
        rst = 1'b1;
        tick;
        check("midrst_duty", int'(duty_out), 0);
        check("midrst_bits", int'(bits_out), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_ready", int'(cfg_ready), 0);
        tick;
        rst = 1'b0;
        #1;
        check("midrst_ready_after", int'(cfg_ready), 1);
        exp_q.delete();
        done_cnt = 0;
        run_vec(9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
